// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, defaults and sizing helpers for spi_master
// Contents:
//   spi_state_e  : IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP (3-bit encoding)
//   SPI_WORD_W   : default transaction width
//   *_MIN/*_MAX  : legal parameter bounds checked at elaboration
//   cnt_w        : counter width able to hold 0..n-1 (never below 1 bit)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    GAP      = 3'd4
  } spi_state_e;

  localparam int SPI_WORD_W     = 32;
  localparam int SPI_WORD_W_MIN = 8;
  localparam int SPI_WORD_W_MAX = 32;
  localparam int CLK_DIV_MIN    = 1;
  localparam int CS_IDLE_MIN    = 2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider producing rise/fall strobes and the registered SPI clock
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : high only while the master is in SHIFT; low clears divider and sclk
//   rise_tick  : strobe in the cycle whose closing edge raises sclk
//   fall_tick  : strobe in the cycle whose closing edge lowers sclk
//   sclk       : registered SPI clock, idles low
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // Strobes lead the sclk register so the master can act on the same edge
  // that moves sclk.
  assign tick      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = tick && !sclk;
  assign fall_tick = tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master with enable/done/busy handshake for the codec control port
// Optional feature macro: SPI_MASTER_READBACK_EN (MISO capture into o_rx_data; else o_rx_data=0)
// Ports:
//   i_clock, i_reset : system clock, asynchronous active-high reset
//   i_enable, i_data : transaction request (level, sampled in IDLE) and word captured at launch
//   o_done           : one-cycle pulse at transaction end
//   o_busy           : high from launch through the end of the inter-transaction gap
//   o_rx_data        : last word shifted in from MISO
//   o_sclk, o_mosi, o_cs_n, i_miso : SPI bus (CCLK, CDATA, CLATCH, COUT)
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = SPI_WORD_W,
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [SPI_DATA_WIDTH-1:0] i_data,
  output logic                      o_done,
  output logic                      o_busy,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_sclk,
  output logic                      o_mosi,
  output logic                      o_cs_n,
  input  logic                      i_miso
);

  localparam int W     = SPI_DATA_WIDTH;
  localparam int BIT_W = cnt_w(W);
  localparam int PH_W  = cnt_w(max_int(CLK_DIV, CS_IDLE_CYCLES + 1));

  generate
    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV below minimum");
    end
    if (CS_IDLE_CYCLES < CS_IDLE_MIN) begin : g_bad_cs_idle
      $error("spi_master: CS_IDLE_CYCLES below minimum");
    end
    if (W < SPI_WORD_W_MIN || W > SPI_WORD_W_MAX) begin : g_bad_width
      $error("spi_master: SPI_DATA_WIDTH out of range");
    end
  endgenerate

  spi_state_e       state;
  logic [PH_W-1:0]  ph_cnt;
  logic [BIT_W-1:0] bit_cnt;
  // The MSB goes straight to o_mosi at launch, so only the remaining bits are kept.
  logic [W-2:0]     tx_sr;

  logic shift_en;
  logic rise_tick;
  logic fall_tick;
  logic phase_end;
  logic hold_end;
  logic last_fall;

  assign shift_en  = (state == SHIFT);
  assign phase_end = (ph_cnt == PH_W'(CLK_DIV - 1));
  assign hold_end  = (state == CS_HOLD) && phase_end;
  assign last_fall = fall_tick && (bit_cnt == BIT_W'(W - 1));

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (i_clock),
    .rst      (i_reset),
    .en       (shift_en),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .sclk     (o_sclk)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      o_cs_n  <= 1'b1;
      o_mosi  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            tx_sr  <= i_data[W-2:0];
            o_mosi <= i_data[W-1];
            o_cs_n <= 1'b0;
            o_busy <= 1'b1;
            ph_cnt <= '0;
            state  <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (phase_end) begin
            ph_cnt  <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        SHIFT: begin
          // bit_cnt counts falling edges; the last one ends the frame
          // without presenting a further bit, so o_mosi keeps the LSB.
          if (fall_tick) begin
            if (last_fall) begin
              bit_cnt <= '0;
              ph_cnt  <= '0;
              state   <= CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_mosi  <= tx_sr[W-2];
              tx_sr   <= {tx_sr[W-3:0], 1'b0};
            end
          end
        end
        CS_HOLD: begin
          if (hold_end) begin
            o_cs_n <= 1'b1;
            o_done <= 1'b1;
            ph_cnt <= '0;
            state  <= GAP;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        GAP: begin
          // The done cycle plus CS_IDLE_CYCLES more: covers the sequencer
          // dropping i_enable a cycle after it sees o_done.
          if (ph_cnt == PH_W'(CS_IDLE_CYCLES)) begin
            ph_cnt <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_READBACK_EN
  logic [W-1:0] rx_sr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_sr     <= '0;
      o_rx_data <= '0;
    end else begin
      if (rise_tick) begin
        rx_sr <= {rx_sr[W-2:0], i_miso};
      end
      if (hold_end) begin
        o_rx_data <= rx_sr;
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{i_miso, rise_tick};
  assign o_rx_data = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized scoreboard bench for spi_master (32b/div4 and 8b/div1 instances)
module tb_spi_master;

  localparam int W0 = 32;
  localparam int D0 = 4;
  localparam int W1 = 8;
  localparam int D1 = 1;
  localparam int CI = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] slave;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en0, done0, busy0, sclk0, mosi0, cs_n0, miso0;
  logic [31:0] data0, rx0;
  logic        en1, done1, busy1, sclk1, mosi1, cs_n1, miso1;
  logic [7:0]  data1, rx1;

  spi_master #(.SPI_DATA_WIDTH(W0), .CLK_DIV(D0), .CS_IDLE_CYCLES(CI)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_enable(en0), .i_data(data0),
    .o_done(done0), .o_busy(busy0), .o_rx_data(rx0), .o_sclk(sclk0),
    .o_mosi(mosi0), .o_cs_n(cs_n0), .i_miso(miso0)
  );

  spi_master #(.SPI_DATA_WIDTH(W1), .CLK_DIV(D1), .CS_IDLE_CYCLES(CI)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en1), .i_data(data1),
    .o_done(done1), .o_busy(busy1), .o_rx_data(rx1), .o_sclk(sclk1),
    .o_mosi(mosi1), .o_cs_n(cs_n1), .i_miso(miso1)
  );

  logic [1:0]  done_v, busy_v, sclk_v, mosi_v, cs_v;
  logic [31:0] rx_v [2];
  assign done_v  = {done1, done0};
  assign busy_v  = {busy1, busy0};
  assign sclk_v  = {sclk1, sclk0};
  assign mosi_v  = {mosi1, mosi0};
  assign cs_v    = {cs_n1, cs_n0};
  assign rx_v[0] = rx0;
  assign rx_v[1] = {24'h0, rx1};

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h (t=%0t)", k, name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input int k, input string name);
    checks++;
    failures++;
    $display("FAIL dut%0d %s (t=%0t)", k, name, $time);
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  // Monitor + slave model: watches both buses, feeds MISO MSB-first (valid
  // before each rising SCLK), and scores every o_done against the queue.
  initial begin : monitor
    bit          act [2];
    bit          have_done [2];
    int          rises [2];
    int          t_launch [2];
    int          t_done [2];
    logic [31:0] mword [2];
    logic [31:0] sw [2];
    logic        prev_cs [2];
    logic        prev_sclk [2];
    exp_t        e;
    int          w;
    int          d;
    int          qsz;
    logic [31:0] exp_rx;
    logic        mbit;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; have_done[k] = 0; rises[k] = 0; t_launch[k] = 0; t_done[k] = 0;
      mword[k] = 0; sw[k] = 0; prev_cs[k] = 1'b1; prev_sclk[k] = 1'b0;
    end
    miso0 = 1'b0;
    miso1 = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        w = width_of(k);
        d = div_of(k);
        qsz = (k == 0) ? sb0.size() : sb1.size();
        if (rst) begin
          act[k] = 0;
          prev_cs[k] = 1'b1;
          prev_sclk[k] = 1'b0;
        end else begin
          if (have_done[k] && cyc == t_done[k] + CI)
            chk(k, "busy_in_gap", {31'b0, busy_v[k]}, 32'd1);
          if (have_done[k] && cyc == t_done[k] + CI + 1)
            chk(k, "busy_after_gap", {31'b0, busy_v[k]}, 32'd0);
          if (prev_cs[k] && !cs_v[k]) begin
            if (qsz == 0) begin
              fail_evt(k, "unexpected_launch");
            end else begin
              e = (k == 0) ? sb0[0] : sb1[0];
              sw[k] = e.slave;
              act[k] = 1;
              rises[k] = 0;
              mword[k] = 0;
              t_launch[k] = cyc;
              if (have_done[k])
                chk(k, "launch_gap_ok", {31'b0, (cyc - t_done[k]) >= (CI + 1)}, 32'd1);
            end
          end
          if (act[k] && sclk_v[k] && !prev_sclk[k]) begin
            mword[k] = {mword[k][30:0], mosi_v[k]};
            rises[k]++;
          end
          if (done_v[k]) begin
            if (!act[k] || qsz == 0) begin
              fail_evt(k, "unexpected_done");
            end else begin
              e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
`ifdef SPI_MASTER_READBACK_EN
              exp_rx = e.slave & mask_of(k);
`else
              exp_rx = 32'h0;
`endif
              chk(k, "done_latency", cyc - t_launch[k], (2 * w + 2) * d);
              chk(k, "sclk_rises", rises[k], w);
              chk(k, "mosi_word", mword[k] & mask_of(k), e.data & mask_of(k));
              chk(k, "rx_data", rx_v[k], exp_rx);
              chk(k, "cs_n_at_done", {31'b0, cs_v[k]}, 32'd1);
              chk(k, "mosi_hold", {31'b0, mosi_v[k]}, {31'b0, e.data[0]});
            end
            act[k] = 0;
            have_done[k] = 1;
            t_done[k] = cyc;
          end
          prev_cs[k] = cs_v[k];
          prev_sclk[k] = sclk_v[k];
        end
        mbit = (act[k] && rises[k] < w) ? sw[k][w - 1 - rises[k]] : 1'b0;
        if (k == 0) miso0 = mbit;
        else        miso1 = mbit;
      end
    end
  end

  task automatic set_en(input int k, input logic v);
    if (k == 0) en0 = v;
    else        en1 = v;
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    if (k == 0) data0 = v;
    else        data1 = v[7:0];
  endtask

  task automatic push(input int k, input logic [31:0] data, input logic [31:0] slave);
    exp_t e;
    e.data  = data;
    e.slave = slave;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic int budget_of(input int k);
    return (2 * width_of(k) + 2) * div_of(k) + 3 * CI + 20;
  endfunction

  task automatic wait_done(input int k, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done_v[k]) return;
    end
    fail_evt(k, "done_timeout");
  endtask

  task automatic wait_launch(input int k, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!cs_v[k]) return;
    end
    fail_evt(k, "launch_timeout");
  endtask

  // Sequencer-style: hold enable until done, drop it one cycle later.
  task automatic run_seq(input int k, input logic [31:0] data, input logic [31:0] slave);
    push(k, data, slave);
    set_data(k, data);
    set_en(k, 1'b1);
    wait_done(k, budget_of(k));
    @(negedge clk);
    set_en(k, 1'b0);
  endtask

  initial begin : stim
    logic [31:0] d;
    logic [31:0] s;
    rst = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    data0 = 32'h0; data1 = 8'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_cs_n", {31'b0, cs_v[k]}, 32'd1);
      chk(k, "rst_sclk", {31'b0, sclk_v[k]}, 32'd0);
      chk(k, "rst_mosi", {31'b0, mosi_v[k]}, 32'd0);
      chk(k, "rst_busy", {31'b0, busy_v[k]}, 32'd0);
      chk(k, "rst_done", {31'b0, done_v[k]}, 32'd0);
      chk(k, "rst_rx", rx_v[k], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_seq(0, 32'h0040_0007, 32'hA5C3_0F96);
    repeat (20) @(negedge clk);
    chk(0, "no_relaunch_cs_n", {31'b0, cs_n0}, 32'd1);
    chk(0, "no_relaunch_busy", {31'b0, busy0}, 32'd0);
    chk(0, "sb_drained", sb0.size(), 32'd0);

    // Enable held across two words; second word written while busy.
    push(0, 32'h0000_0000, $urandom);
    push(0, 32'h0040_1501, $urandom);
    data0 = 32'h0000_0000;
    en0 = 1'b1;
    wait_launch(0, 50);
    data0 = 32'h0040_1501;
    wait_done(0, budget_of(0));
    wait_done(0, budget_of(0));
    @(negedge clk);
    en0 = 1'b0;

    repeat (4) run_seq(0, $urandom, $urandom);

    run_seq(1, 32'h81, 32'h5A);
    repeat (3) run_seq(1, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (10) @(negedge clk);

    // Abort around bit 10 of SHIFT, then relaunch straight out of reset.
    d = $urandom;
    push(0, d, $urandom);
    data0 = d;
    en0 = 1'b1;
    wait_launch(0, 50);
    repeat (2 * D0 + 20 * D0) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(0, "abort_cs_n", {31'b0, cs_n0}, 32'd1);
    chk(0, "abort_sclk", {31'b0, sclk0}, 32'd0);
    chk(0, "abort_busy", {31'b0, busy0}, 32'd0);
    chk(0, "abort_done", {31'b0, done0}, 32'd0);
    sb0.delete();
    d = $urandom;
    s = $urandom;
    push(0, d, s);
    data0 = d;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(0, "launch_after_reset", {31'b0, cs_n0}, 32'd0);
    wait_done(0, budget_of(0));
    @(negedge clk);
    en0 = 1'b0;
    repeat (20) @(negedge clk);

    chk(0, "final_sb_empty", sb0.size(), 32'd0);
    chk(1, "final_sb_empty", sb1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
